// File: rtl/rx_word_align_pkg.sv
// rtl/rx_word_align_pkg.sv - shared constants and state type for the comma aligner
package rx_word_align_pkg;

  localparam logic [7:0] K28_5          = 8'hBC;
  localparam int         FRAME_LEN_DEF  = 20;
  localparam int         LOCK_CNT_DEF   = 3;
  localparam int         UNLOCK_CNT_DEF = 4;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/rx_word_align_if.sv
// rtl/rx_word_align_if.sv - raw word in / aligned word out bundle; RX_WORD_ALIGN_STATS_EN adds counters
interface rx_word_align_if;

  logic [15:0] rx_data;
  logic [1:0]  rx_charisk;
  logic [15:0] data_out;
  logic [1:0]  charisk_out;
  logic        locked;
  logic        offset;
`ifdef RX_WORD_ALIGN_STATS_EN
  logic [15:0] lock_loss_cnt;
  logic [15:0] bad_comma_cnt;
`endif

  modport master (
    output rx_data, rx_charisk,
    input  data_out, charisk_out, locked, offset
`ifdef RX_WORD_ALIGN_STATS_EN
    , input lock_loss_cnt, bad_comma_cnt
`endif
  );

  modport slave (
    input  rx_data, rx_charisk,
    output data_out, charisk_out, locked, offset
`ifdef RX_WORD_ALIGN_STATS_EN
    , output lock_loss_cnt, bad_comma_cnt
`endif
  );

endinterface

// File: rtl/rx_byte_shift.sv
// rtl/rx_byte_shift.sv - s1 word register, per-byte K28.5 detect and byte-offset mux
module rx_byte_shift
  import rx_word_align_pkg::*;
(
  input  logic        clk_wr,
  input  logic        rst_n,
  input  logic [15:0] i_rx_data,
  input  logic [1:0]  i_rx_charisk,
  input  logic        i_sel,
  output logic        o_lo_comma,
  output logic        o_hi_comma,
  output logic [15:0] o_data,
  output logic [1:0]  o_k
);

  logic [15:0] r_s1_data;
  logic [1:0]  r_s1_k;

  always_ff @(posedge clk_wr) begin
    if (!rst_n) begin
      r_s1_data <= 16'h0000;
      r_s1_k    <= 2'b00;
    end else begin
      r_s1_data <= i_rx_data;
      r_s1_k    <= i_rx_charisk;
    end
  end

  // 2'b11 deliberately matches neither pattern
  assign o_lo_comma = (r_s1_data[7:0]  == K28_5) && (r_s1_k == 2'b01);
  assign o_hi_comma = (r_s1_data[15:8] == K28_5) && (r_s1_k == 2'b10);

  // offset 1 borrows the earlier byte of the live input to complete the word
  always_comb begin
    o_data = r_s1_data;
    o_k    = r_s1_k;
    if (i_sel) begin
      o_data = {i_rx_data[7:0], r_s1_data[15:8]};
      o_k    = {i_rx_charisk[0], r_s1_k[1]};
    end
  end

endmodule

// File: rtl/rx_word_align.sv
// rtl/rx_word_align.sv - comma aligner and frame-lock FSM; RX_WORD_ALIGN_STATS_EN adds loss/bad counters
module rx_word_align
  import rx_word_align_pkg::*;
#(
  parameter int FRAME_LEN  = FRAME_LEN_DEF,
  parameter int LOCK_CNT   = LOCK_CNT_DEF,
  parameter int UNLOCK_CNT = UNLOCK_CNT_DEF
) (
  input  logic         clk_wr,
  input  logic         rst_n,
  rx_word_align_if.slave bus
);

  localparam int PW = $clog2(FRAME_LEN + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);

  state_t      r_state, w_state_nxt;
  logic [PW-1:0] r_pos, w_pos_nxt, w_pos_inc;
  logic [GW-1:0] r_good, w_good_nxt;
  logic [BW-1:0] r_bad, w_bad_nxt;
  logic        r_offset, w_offset_nxt;
  logic [15:0] r_data_out;
  logic [1:0]  r_charisk_out, w_charisk_nxt;

  logic        w_lo_comma, w_hi_comma, w_comma, w_expected, w_good_comma;
  logic [15:0] w_aligned_data;
  logic [1:0]  w_aligned_k;

  // mux follows the next offset so the comma that is accepted is already aligned
  rx_byte_shift u_shift (
    .clk_wr       (clk_wr),
    .rst_n        (rst_n),
    .i_rx_data    (bus.rx_data),
    .i_rx_charisk (bus.rx_charisk),
    .i_sel        (w_offset_nxt),
    .o_lo_comma   (w_lo_comma),
    .o_hi_comma   (w_hi_comma),
    .o_data       (w_aligned_data),
    .o_k          (w_aligned_k)
  );

  assign w_comma      = w_lo_comma || w_hi_comma;
  assign w_expected   = (r_pos == PW'(FRAME_LEN));
  assign w_good_comma = w_comma && w_expected && (w_hi_comma == r_offset);
  assign w_pos_inc    = w_expected ? PW'(1) : r_pos + PW'(1);

  always_ff @(posedge clk_wr) begin
    if (!rst_n) begin
      r_state       <= HUNT;
      r_pos         <= '0;
      r_good        <= '0;
      r_bad         <= '0;
      r_offset      <= 1'b0;
      r_data_out    <= 16'h0000;
      r_charisk_out <= 2'b00;
    end else begin
      r_state       <= w_state_nxt;
      r_pos         <= w_pos_nxt;
      r_good        <= w_good_nxt;
      r_bad         <= w_bad_nxt;
      r_offset      <= w_offset_nxt;
      r_data_out    <= w_aligned_data;
      r_charisk_out <= w_charisk_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pos_nxt    = w_pos_inc;
    w_good_nxt   = r_good;
    w_bad_nxt    = r_bad;
    w_offset_nxt = r_offset;
    case (r_state)
      HUNT: begin
        if (w_comma) begin
          w_offset_nxt = w_hi_comma;
          w_pos_nxt    = PW'(1);
          w_good_nxt   = GW'(1);
          w_bad_nxt    = '0;
          w_state_nxt  = (LOCK_CNT == 1) ? LOCKED : VERIFY;
        end
      end
      VERIFY: begin
        if (w_good_comma) begin
          w_good_nxt = r_good + GW'(1);
          if (r_good + GW'(1) == GW'(LOCK_CNT)) begin
            w_state_nxt = LOCKED;
            w_bad_nxt   = '0;
          end
        end else if (w_expected || w_comma) begin
          w_state_nxt = HUNT;
          w_good_nxt  = '0;
        end
      end
      LOCKED: begin
        // stray commas are counted but never re-phase pos or offset
        if (w_good_comma) begin
          w_bad_nxt = '0;
        end else if (w_expected || w_comma) begin
          if (r_bad + BW'(1) == BW'(UNLOCK_CNT)) begin
            w_state_nxt = HUNT;
            w_bad_nxt   = '0;
            w_good_nxt  = '0;
          end else begin
            w_bad_nxt = r_bad + BW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = HUNT;
      end
    endcase
  end

  always_comb begin
    w_charisk_nxt = 2'b00;
    if (w_state_nxt == LOCKED) begin
      w_charisk_nxt = w_aligned_k;
    end
  end

  assign bus.data_out    = r_data_out;
  assign bus.charisk_out = r_charisk_out;
  assign bus.locked      = (r_state == LOCKED);
  assign bus.offset      = r_offset;

`ifdef RX_WORD_ALIGN_STATS_EN
  logic [15:0] r_lock_loss_cnt, r_bad_comma_cnt;
  logic        w_loss_evt, w_bad_evt;

  assign w_loss_evt = (r_state == LOCKED) && (w_state_nxt == HUNT);
  assign w_bad_evt  = (r_state == LOCKED) && !w_good_comma && (w_expected || w_comma);

  always_ff @(posedge clk_wr) begin
    if (!rst_n) begin
      r_lock_loss_cnt <= 16'h0000;
      r_bad_comma_cnt <= 16'h0000;
    end else begin
      if (w_loss_evt && (r_lock_loss_cnt != 16'hFFFF)) begin
        r_lock_loss_cnt <= r_lock_loss_cnt + 16'h0001;
      end
      if (w_bad_evt && (r_bad_comma_cnt != 16'hFFFF)) begin
        r_bad_comma_cnt <= r_bad_comma_cnt + 16'h0001;
      end
    end
  end

  assign bus.lock_loss_cnt = r_lock_loss_cnt;
  assign bus.bad_comma_cnt = r_bad_comma_cnt;
`endif

endmodule
